// File: rtl/axi_burst_write_slave.sv
// AXI write-only burst slave backed by a small word array.
// One burst is in flight at a time: AW is taken in IDLE, beats are absorbed
// in DATA, a single B response is returned in RESP. The array is readable
// through a registered side port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an AW handshake (awready_o high after reset)
// DATA  | absorbing exactly awlen+1 W beats into the array
// RESP  | presenting the B response until bready_i
module axi_burst_write_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                   STRB_W     = DATA_WIDTH / 8,
  localparam int                   RA_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [3:0]            awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [7:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [3:0]            wid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [3:0]            bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [RA_W-1:0]       rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  wr_done_o
);

  localparam int              LG_BYTES = $clog2(STRB_W);
  // Index is one bit wider than the address so an INCR run past the top can
  // never fold back into the array range.
  localparam int              IDX_W    = ADDR_WIDTH + 1;
  localparam logic [RA_W:0]   DEPTH_RA = (RA_W + 1)'(DEPTH);
  localparam logic [1:0]      BURST_INCR = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  live_q;
  logic [3:0]            id_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic                  err_type_q;
  logic                  err_q;
  logic                  wr_done_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_hs, beat, last_beat, b_hs;
  logic                  aw_err, idx_in_range;
  logic [IDX_W-1:0]      idx_start;
  logic [RA_W-1:0]       idx_wr;

  assign aw_hs        = awvalid_i && awready_o;
  assign beat         = wvalid_i && wready_o;
  assign last_beat    = beat && (cnt_q == 8'd0);
  assign b_hs         = bvalid_o && bready_i;
  assign aw_err       = awburst_i[1] || (awsize_i != 3'(LG_BYTES));
  assign idx_start    = IDX_W'((awaddr_i - BASE_ADDR) >> LG_BYTES);
  assign idx_in_range = idx_q < IDX_W'(DEPTH);
  assign idx_wr       = idx_q[RA_W-1:0];
  assign wr_done_o    = wr_done_q;
  assign rd_data_o    = rd_data_q;

  // State register; live_q holds awready low until the first edge after reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (aw_hs)     state_d = S_DATA;
      S_DATA:  if (last_beat) state_d = S_RESP;
      S_RESP:  if (b_hs)      state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake and response outputs, decoded from the current state.
  always_comb begin
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bid_o     = 4'd0;
    bresp_o   = 2'b00;
    case (state_q)
      S_IDLE: awready_o = live_q;
      S_DATA: wready_o  = 1'b1;
      S_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = id_q;
        bresp_o  = err_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // Burst context: captured on AW, advanced per beat, errors accumulated.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      id_q       <= 4'd0;
      idx_q      <= '0;
      cnt_q      <= 8'd0;
      burst_q    <= 2'b00;
      err_type_q <= 1'b0;
      err_q      <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_done_q <= b_hs;
      if (aw_hs) begin
        id_q       <= awid_i;
        idx_q      <= idx_start;
        cnt_q      <= awlen_i;
        burst_q    <= awburst_i;
        err_type_q <= aw_err;
        err_q      <= aw_err;
      end else if (beat) begin
        if (!idx_in_range || (wid_i != id_q) || (wlast_i != (cnt_q == 8'd0)))
          err_q <= 1'b1;
        if (burst_q == BURST_INCR)
          idx_q <= idx_q + IDX_W'(1);
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Word array: byte-lane writes for accepted, in-range beats of clean bursts.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (beat && !err_type_q && idx_in_range) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb_i[b]) mem[idx_wr][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Registered read-back; a write in the same cycle is seen one cycle later.
  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      rd_data_q <= '0;
    else if ({1'b0, rd_addr_i} < DEPTH_RA)
      rd_data_q <= mem[rd_addr_i];
    else
      rd_data_q <= '0;
  end

endmodule

// File: tb/tb_axi_burst_write_slave.sv
// Bench for axi_burst_write_slave: a table of bursts checked against a
// behavioural array model and a B-response scoreboard, plus hand sequences
// for read-back timing, backpressure and reset mid-burst.
module tb_axi_burst_write_slave;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic [3:0]    awid_i;
  logic [AW-1:0] awaddr_i;
  logic [7:0]    awlen_i;
  logic [2:0]    awsize_i;
  logic [1:0]    awburst_i;
  logic          awvalid_i;
  logic          awready_o;
  logic [3:0]    wid_i;
  logic [DW-1:0] wdata_i;
  logic [3:0]    wstrb_i;
  logic          wlast_i;
  logic          wvalid_i;
  logic          wready_o;
  logic [3:0]    bid_o;
  logic [1:0]    bresp_o;
  logic          bvalid_o;
  logic          bready_i;
  logic [3:0]    rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          wr_done_o;

  axi_burst_write_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR('0)
  ) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .wr_done_o(wr_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  wid;
    logic [31:0] data0;
    logic [3:0]  strb;
    int          last_at;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  vec_t        vecs [9];
  bexp_t       sb_q [$];
  logic [31:0] model [DEPTH];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = size;
    awvalid_i = 1'b1;
    while (!awready_o && n < 50) begin tick(); n++; end
    if (!awready_o) tmo("aw_accept");
    tick();
    awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] wid);
    int n = 0;
    wdata_i = data; wstrb_i = strb; wlast_i = last; wid_i = wid;
    wvalid_i = 1'b1;
    while (!wready_o && n < 50) begin tick(); n++; end
    if (!wready_o) tmo("w_accept");
    tick();
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
  endtask

  task automatic b_collect(input string name);
    int    n = 0;
    bexp_t e;
    bready_i = 1'b1;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    if (!bvalid_o) begin
      tmo({name, "_bvalid"});
    end else if (sb_q.size() == 0) begin
      tmo({name, "_unexpected_b"});
    end else begin
      e = sb_q.pop_front();
      chk({name, "_bid"},   32'(bid_o),   32'(e.id));
      chk({name, "_bresp"}, 32'(bresp_o), 32'(e.resp));
      tick();
      chk({name, "_wr_done"},  32'(wr_done_o), 32'd1);
      chk({name, "_bvalid_0"}, 32'(bvalid_o),  32'd0);
      chk({name, "_awready"},  32'(awready_o), 32'd1);
    end
    bready_i = 1'b0;
  endtask

  task automatic model_beat(input vec_t v, input int k);
    int idx;
    if (v.burst[1] || v.size != 3'd2) return;
    idx = int'(v.addr >> 2) + ((v.burst == 2'b01) ? k : 0);
    if (idx >= DEPTH) return;
    for (int b = 0; b < 4; b++)
      if (v.strb[b]) model[idx][b*8 +: 8] = 8'(v.data0 + 32'(k) >> (b*8));
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_i = 4'(i);
      tick();
      chk($sformatf("%s_mem%0d", tag, i), rd_data_o, model[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h5, 32'h08, 8'd3, 2'b01, 3'd2, 4'h5, 32'hA0,       4'hF, 3, 2'b00};
    vecs[1] = '{4'h1, 32'h10, 8'd2, 2'b00, 3'd2, 4'h1, 32'h1,        4'hF, 2, 2'b00};
    vecs[2] = '{4'h2, 32'h00, 8'd0, 2'b01, 3'd2, 4'h2, 32'hFFFFFFFF, 4'hF, 0, 2'b00};
    vecs[3] = '{4'h2, 32'h00, 8'd0, 2'b01, 3'd2, 4'h2, 32'h12345678, 4'h5, 0, 2'b00};
    vecs[4] = '{4'h6, 32'h38, 8'd3, 2'b01, 3'd2, 4'h6, 32'hC0,       4'hF, 3, 2'b10};
    vecs[5] = '{4'h7, 32'h20, 8'd1, 2'b10, 3'd2, 4'h7, 32'hD0,       4'hF, 1, 2'b10};
    vecs[6] = '{4'h8, 32'h24, 8'd3, 2'b01, 3'd2, 4'h8, 32'hE0,       4'hF, 1, 2'b10};
    vecs[7] = '{4'h5, 32'h30, 8'd0, 2'b01, 3'd2, 4'h3, 32'h55,       4'hF, 0, 2'b10};
    vecs[8] = '{4'h9, 32'h04, 8'd0, 2'b01, 3'd1, 4'h9, 32'h77,       4'hF, 0, 2'b10};

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    areset = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
    bready_i = 1'b0; rd_addr_i = '0;

    tick(); tick();
    chk("rst_awready", 32'(awready_o), 32'd0);
    chk("rst_wready",  32'(wready_o),  32'd0);
    chk("rst_bvalid",  32'(bvalid_o),  32'd0);
    chk("rst_bid",     32'(bid_o),     32'd0);
    chk("rst_bresp",   32'(bresp_o),   32'd0);
    chk("rst_wr_done", 32'(wr_done_o), 32'd0);
    chk("rst_rd_data", rd_data_o,      32'd0);
    areset = 1'b0;
    #1 chk("rel_awready_pre", 32'(awready_o), 32'd0);
    tick();
    chk("rel_awready_post", 32'(awready_o), 32'd1);

    for (int v = 0; v < 9; v++) begin
      sb_q.push_back('{vecs[v].id, vecs[v].exp_resp});
      aw_send(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size);
      chk($sformatf("v%0d_wready_after_aw", v), 32'(wready_o), 32'd1);
      for (int k = 0; k <= int'(vecs[v].len); k++) begin
        w_send(vecs[v].data0 + 32'(k), vecs[v].strb, (k == vecs[v].last_at), vecs[v].wid);
        model_beat(vecs[v], k);
      end
      chk($sformatf("v%0d_wready_drop", v), 32'(wready_o), 32'd1 - 32'd1);
      chk($sformatf("v%0d_bvalid_rise", v), 32'(bvalid_o), 32'd1);
      b_collect($sformatf("v%0d", v));
    end

    rd_addr_i = 4'd2;
    tick();
    chk("rd_word2", rd_data_o, 32'hA0);
    rd_addr_i = 4'd3;
    #1 chk("rd_latency_old", rd_data_o, 32'hA0);
    tick();
    chk("rd_latency_new", rd_data_o, 32'hA1);
    check_array("tbl");

    sb_q.push_back('{4'h3, 2'b00});
    aw_send(4'h3, 32'h04, 8'd0, 2'b01, 3'd2);
    rd_addr_i = 4'd1;
    w_send(32'h11, 4'hF, 1'b1, 4'h3);
    chk("rd_same_cycle_old", rd_data_o, model[1]);
    model[1] = 32'h11;
    tick();
    chk("rd_same_cycle_new", rd_data_o, 32'h11);
    b_collect("same_cycle");

    sb_q.push_back('{4'hA, 2'b00});
    aw_send(4'hA, 32'h18, 8'd0, 2'b01, 3'd2);
    w_send(32'h66, 4'hF, 1'b1, 4'hA);
    model[6] = 32'h66;
    awid_i = 4'hB; awaddr_i = 32'h1C; awlen_i = 8'd0; awburst_i = 2'b01; awsize_i = 3'd2;
    awvalid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_bvalid", c),  32'(bvalid_o),  32'd1);
      chk($sformatf("bp%0d_bid", c),     32'(bid_o),     32'hA);
      chk($sformatf("bp%0d_bresp", c),   32'(bresp_o),   32'd0);
      chk($sformatf("bp%0d_awready", c), 32'(awready_o), 32'd0);
      tick();
    end
    begin
      bexp_t e;
      e = sb_q.pop_front();
      chk("bp_bid_sb", 32'(bid_o), 32'(e.id));
    end
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
    chk("bp_wr_done", 32'(wr_done_o), 32'd1);
    chk("bp_bvalid_0", 32'(bvalid_o), 32'd0);
    chk("bp_awready_next", 32'(awready_o), 32'd1);
    sb_q.push_back('{4'hB, 2'b00});
    tick();
    awvalid_i = 1'b0;
    chk("bp_next_aw_taken", 32'(wready_o), 32'd1);
    chk("bp_wr_done_pulse", 32'(wr_done_o), 32'd0);
    w_send(32'h77, 4'hF, 1'b1, 4'hB);
    model[7] = 32'h77;
    b_collect("after_bp");
    check_array("bp");

    aw_send(4'hC, 32'h20, 8'd3, 2'b01, 3'd2);
    w_send(32'h91, 4'hF, 1'b0, 4'hC);
    w_send(32'h92, 4'hF, 1'b0, 4'hC);
    rd_addr_i = 4'd2;
    tick();
    chk("mid_rd_before_rst", rd_data_o, 32'hA0);
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_wready",  32'(wready_o),  32'd0);
    chk("mid_rst_awready", 32'(awready_o), 32'd0);
    chk("mid_rst_bvalid",  32'(bvalid_o),  32'd0);
    chk("mid_rst_rd_data", rd_data_o,      32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick(); tick();
    areset = 1'b0;
    #1 chk("mid_rel_awready_pre", 32'(awready_o), 32'd0);
    tick();
    chk("mid_rel_awready_post", 32'(awready_o), 32'd1);
    bready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mid_no_b%0d", c), 32'(bvalid_o), 32'd0);
      tick();
    end
    bready_i = 1'b0;
    check_array("mid_rst");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
